// File: rtl/gc_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gc_fetch_pkg
// Description : Shared types and constants for the garbled-label operand
//               fetch unit (port FSM states, counter widths, saturating add).
// Revision    : 1.0 - initial release
// ============================================================================
package gc_fetch_pkg;

  typedef enum logic [1:0] {
    P_IDLE = 2'd0,
    P_WAIT = 2'd1,
    P_READ = 2'd2,
    P_DONE = 2'd3
  } port_state_t;

  localparam int STALL_W = 32;
  localparam int WAITC_W = 10;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [STALL_W-1:0] sat_inc_stall(input logic [STALL_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/gate_operand_fetch_if.sv
`default_nettype none
// ============================================================================
// Module      : gate_operand_fetch_if
// Description : Request and label-pair handshake bundle between the gate
//               scheduler (master) and the operand fetch unit (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface gate_operand_fetch_if #(
  parameter int S = 20,
  parameter int K = 128
);

  logic         req_valid;
  logic         req_ready;
  logic         req_single;
  logic [S-1:0] req_addr_a;
  logic [S-1:0] req_addr_b;
  logic         out_valid;
  logic         out_ready;
  logic [K-1:0] out_label_a;
  logic [K-1:0] out_label_b;

  modport master (
    output req_valid, req_single, req_addr_a, req_addr_b, out_ready,
    input  req_ready, out_valid, out_label_a, out_label_b
  );

  modport slave (
    input  req_valid, req_single, req_addr_a, req_addr_b, out_ready,
    output req_ready, out_valid, out_label_a, out_label_b
  );

endinterface
`default_nettype wire

// File: rtl/label_port_reader.sv
`default_nettype none
// ============================================================================
// Module      : label_port_reader
// Description : One RAM read port: latches an operand address, polls the
//               written flag, issues the read when the port is free and
//               captures the label. Tracks per-request wait time and raises
//               a sticky timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module label_port_reader
  import gc_fetch_pkg::*;
#(
  parameter int S   = 20,
  parameter int K   = 128,
  parameter int TMO = 1023
) (
  input  wire logic         clk,
  input  wire logic         rst,
  input  wire logic         clr,
  input  wire logic         accept,
  input  wire logic         skip,
  input  wire logic         done_ack,
  input  wire logic [S-1:0] req_addr,
  input  wire logic         rd_data_ready,
  input  wire logic         busy,
  input  wire logic [K-1:0] rd_data,
  output port_state_t       state,
  output logic [S-1:0]      rd_addr,
  output logic [K-1:0]      label,
  output logic              stalled,
  output logic              timeout
);

  localparam logic [WAITC_W:0] TMO_C = (WAITC_W + 1)'(TMO);

  logic [WAITC_W-1:0] waitc;
  logic [WAITC_W:0]   waitc_inc;
  logic               go;

  assign go        = rd_data_ready && !busy;
  assign waitc_inc = {1'b0, waitc} + 1'b1;
  assign stalled   = (state == P_WAIT) && !go;

  // Port FSM with address/label holding, wait counter and sticky timeout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= P_IDLE;
      rd_addr <= '0;
      label   <= '0;
      waitc   <= '0;
      timeout <= 1'b0;
    end else if (clr) begin
      state   <= P_IDLE;
      rd_addr <= '0;
      label   <= '0;
      waitc   <= '0;
      timeout <= 1'b0;
    end else begin
      unique case (state)
        P_IDLE: begin
          if (accept) begin
            rd_addr <= req_addr;
            waitc   <= '0;
            if (skip) begin
              label <= '0;
              state <= P_DONE;
            end else begin
              state <= P_WAIT;
            end
          end
        end
        P_WAIT: begin
          // The RAM samples rd_addr at the same edge we leave P_WAIT.
          if (go) begin
            state <= P_READ;
          end else begin
            if (!(&waitc)) waitc <= waitc + 1'b1;
            if ((TMO != 0) && (waitc_inc >= TMO_C)) timeout <= 1'b1;
          end
        end
        P_READ: begin
          label <= rd_data;
          state <= P_DONE;
        end
        P_DONE: begin
          if (done_ack) state <= P_IDLE;
        end
        default: state <= P_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/gate_operand_fetch.sv
`default_nettype none
// ============================================================================
// Module      : gate_operand_fetch
// Description : Fetches a gate's operand label pair from the garbled-label
//               dual-port RAM (one reader per port) and hands the pair to the
//               garbler over a valid/ready handshake. Counts stall cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module gate_operand_fetch
  import gc_fetch_pkg::*;
#(
  parameter int S   = 20,
  parameter int K   = 128,
  parameter int TMO = 1023
) (
  input  wire logic          clk,
  input  wire logic          rst,
  input  wire logic          clr,
  gate_operand_fetch_if.slave bus,
  output logic [S-1:0]       rd_addr_0,
  output logic [S-1:0]       rd_addr_1,
  input  wire logic          rd_data_ready_0,
  input  wire logic          rd_data_ready_1,
  input  wire logic          busy_0,
  input  wire logic          busy_1,
  input  wire logic [K-1:0]  rd_data_0,
  input  wire logic [K-1:0]  rd_data_1,
  output logic               err_timeout,
  output logic [STALL_W-1:0] stall_cnt
);

  port_state_t  state_0, state_1;
  logic [K-1:0] label_0, label_1;
  logic         stalled_0, stalled_1;
  logic         timeout_0, timeout_1;
  logic         accept, done_ack, req_ready_w, out_valid_w;

  // Accept only with both ports idle; the handshake cycle has both in P_DONE,
  // so a new request can land no earlier than the following cycle.
  assign req_ready_w = (state_0 == P_IDLE) && (state_1 == P_IDLE);
  assign out_valid_w = (state_0 == P_DONE) && (state_1 == P_DONE);
  assign accept      = bus.req_valid && req_ready_w;
  assign done_ack    = out_valid_w && bus.out_ready;

  assign bus.req_ready   = req_ready_w;
  assign bus.out_valid   = out_valid_w;
  assign bus.out_label_a = label_0;
  // Port 1 loads a zero label when the gate has a single operand.
  assign bus.out_label_b = label_1;
  assign err_timeout     = timeout_0 | timeout_1;

  label_port_reader #(.S(S), .K(K), .TMO(TMO)) u_port_a (
    .clk           (clk),
    .rst           (rst),
    .clr           (clr),
    .accept        (accept),
    .skip          (1'b0),
    .done_ack      (done_ack),
    .req_addr      (bus.req_addr_a),
    .rd_data_ready (rd_data_ready_0),
    .busy          (busy_0),
    .rd_data       (rd_data_0),
    .state         (state_0),
    .rd_addr       (rd_addr_0),
    .label         (label_0),
    .stalled       (stalled_0),
    .timeout       (timeout_0)
  );

  label_port_reader #(.S(S), .K(K), .TMO(TMO)) u_port_b (
    .clk           (clk),
    .rst           (rst),
    .clr           (clr),
    .accept        (accept),
    .skip          (bus.req_single),
    .done_ack      (done_ack),
    .req_addr      (bus.req_addr_b),
    .rd_data_ready (rd_data_ready_1),
    .busy          (busy_1),
    .rd_data       (rd_data_1),
    .state         (state_1),
    .rd_addr       (rd_addr_1),
    .label         (label_1),
    .stalled       (stalled_1),
    .timeout       (timeout_1)
  );

  // One count per cycle in which either port waits without advancing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (clr) begin
      stall_cnt <= '0;
    end else if (stalled_0 || stalled_1) begin
      stall_cnt <= sat_inc_stall(stall_cnt);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_gate_operand_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_gate_operand_fetch
// Description : Directed bench for gate_operand_fetch with a behavioural
//               dual-port label RAM and a label-pair scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gate_operand_fetch;

  localparam int S   = 20;
  localparam int K   = 128;
  localparam int TMO = 8;

  localparam logic [K-1:0] LA  = {16{8'hAA}};
  localparam logic [K-1:0] LB  = {16{8'hBB}};
  localparam logic [K-1:0] LB2 = {16{8'h5B}};
  localparam logic [K-1:0] LC  = {16{8'hC3}};
  localparam logic [K-1:0] LD  = {16{8'h3C}};
  localparam logic [K-1:0] LE  = {16{8'h77}};

  logic clk = 1'b0;
  logic rst;
  logic clr;

  gate_operand_fetch_if #(.S(S), .K(K)) bus ();

  logic [S-1:0] rd_addr_0, rd_addr_1;
  logic         rd_data_ready_0, rd_data_ready_1;
  logic         busy_0, busy_1;
  logic [K-1:0] rd_data_0, rd_data_1;
  logic         err_timeout;
  logic [31:0]  stall_cnt;

  gate_operand_fetch #(.S(S), .K(K), .TMO(TMO)) dut (
    .clk             (clk),
    .rst             (rst),
    .clr             (clr),
    .bus             (bus),
    .rd_addr_0       (rd_addr_0),
    .rd_addr_1       (rd_addr_1),
    .rd_data_ready_0 (rd_data_ready_0),
    .rd_data_ready_1 (rd_data_ready_1),
    .busy_0          (busy_0),
    .busy_1          (busy_1),
    .rd_data_0       (rd_data_0),
    .rd_data_1       (rd_data_1),
    .err_timeout     (err_timeout),
    .stall_cnt       (stall_cnt)
  );

  always #5 clk = ~clk;

  // Behavioural RAM: write sets the flag at the edge, read data registered.
  logic         we;
  logic [7:0]   waddr;
  logic [K-1:0] wdata;
  logic [K-1:0] mem [256];
  logic         flg [256];

  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 256; i++) flg[i] <= 1'b0;
    end else if (we) begin
      mem[waddr] <= wdata;
      flg[waddr] <= 1'b1;
    end
    if (!busy_0) rd_data_0 <= mem[rd_addr_0[7:0]];
    if (!busy_1) rd_data_1 <= mem[rd_addr_1[7:0]];
  end

  assign rd_data_ready_0 = flg[rd_addr_0[7:0]];
  assign rd_data_ready_1 = flg[rd_addr_1[7:0]];

  // Scoreboard
  typedef struct packed {
    logic [K-1:0] a;
    logic [K-1:0] b;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: compare each accepted label pair against the queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("label_a", bus.out_label_a, e.a);
        check("label_b", bus.out_label_b, e.b);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic ram_wr(input logic [7:0] a, input logic [K-1:0] d);
    we = 1'b1; waddr = a; wdata = d;
    tick();
    we = 1'b0;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  // Presents a request for one cycle; returns in the cycle after acceptance.
  task automatic request(input logic [S-1:0] a, input logic [S-1:0] b, input logic single);
    check("req_ready_before_accept", bus.req_ready, 1);
    bus.req_valid  = 1'b1;
    bus.req_addr_a = a;
    bus.req_addr_b = b;
    bus.req_single = single;
    tick();
    bus.req_valid  = 1'b0;
    bus.req_single = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; clr = 1'b0; we = 1'b0; waddr = '0; wdata = '0;
    busy_0 = 1'b0; busy_1 = 1'b0;
    bus.req_valid = 1'b0; bus.req_single = 1'b0;
    bus.req_addr_a = '0; bus.req_addr_b = '0; bus.out_ready = 1'b1;

    tick();
    check("rst_req_ready", bus.req_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_err", err_timeout, 0);
    check("rst_stall", stall_cnt, 0);
    check("rst_rd_addr_0", rd_addr_0, 0);
    tick();
    rst = 1'b0;
    do_clr();

    // Both flags preset: minimum latency.
    ram_wr(8'h10, LA);
    ram_wr(8'h20, LB);
    exp_q.push_back('{a: LA, b: LB});
    request(20'h10, 20'h20, 1'b0);
    check("t1_c1_req_ready", bus.req_ready, 0);
    check("t1_c1_rd_addr_0", rd_addr_0, 20'h10);
    check("t1_c1_rd_addr_1", rd_addr_1, 20'h20);
    check("t1_c1_out_valid", bus.out_valid, 0);
    tick();
    check("t1_c2_out_valid", bus.out_valid, 0);
    tick();
    check("t1_c3_out_valid", bus.out_valid, 1);
    check("t1_c3_req_ready", bus.req_ready, 0);
    tick();
    check("t1_c4_out_valid", bus.out_valid, 0);
    check("t1_c4_req_ready", bus.req_ready, 1);
    check("t1_stall", stall_cnt, 0);

    // Operand B written 5 edges after accept.
    do_clr();
    ram_wr(8'h10, LA);
    exp_q.push_back('{a: LA, b: LB2});
    request(20'h10, 20'h20, 1'b0);
    ticks(4);
    ram_wr(8'h20, LB2);
    check("t2_c6_out_valid", bus.out_valid, 0);
    tick();
    check("t2_c7_out_valid", bus.out_valid, 0);
    tick();
    check("t2_c8_out_valid", bus.out_valid, 1);
    check("t2_stall", stall_cnt, 5);
    tick();

    // Port 1 busy for two cycles with its flag already set.
    do_clr();
    ram_wr(8'h10, LC);
    ram_wr(8'h20, LD);
    exp_q.push_back('{a: LC, b: LD});
    request(20'h10, 20'h20, 1'b0);
    busy_1 = 1'b1;
    ticks(2);
    busy_1 = 1'b0;
    check("t3_c3_out_valid", bus.out_valid, 0);
    tick();
    check("t3_c4_out_valid", bus.out_valid, 0);
    tick();
    check("t3_c5_out_valid", bus.out_valid, 1);
    check("t3_stall", stall_cnt, 2);
    tick();

    // Single-operand gate: B label forced to zero, port 1 flag irrelevant.
    do_clr();
    ram_wr(8'h07, LE);
    exp_q.push_back('{a: LE, b: '0});
    request(20'h7, 20'h20, 1'b1);
    tick();
    tick();
    check("t4_c3_out_valid", bus.out_valid, 1);
    check("t4_stall", stall_cnt, 0);
    tick();

    // Downstream back-pressure for four cycles.
    ram_wr(8'h20, LB);
    bus.out_ready = 1'b0;
    exp_q.push_back('{a: LE, b: LB});
    request(20'h7, 20'h20, 1'b0);
    ticks(2);
    for (int i = 0; i < 4; i++) begin
      check("t5_hold_valid", bus.out_valid, 1);
      check("t5_hold_label_a", bus.out_label_a, LE);
      check("t5_hold_label_b", bus.out_label_b, LB);
      tick();
    end
    bus.out_ready = 1'b1;
    tick();
    check("t5_after_out_valid", bus.out_valid, 0);
    check("t5_after_req_ready", bus.req_ready, 1);

    // clr while both ports wait on unset flags.
    do_clr();
    request(20'h10, 20'h20, 1'b0);
    tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("clr_out_valid", bus.out_valid, 0);
    check("clr_req_ready", bus.req_ready, 1);
    check("clr_stall", stall_cnt, 0);

    // Timeout after TMO wait cycles, then async reset while a port reads.
    request(20'h10, 20'h20, 1'b0);
    ticks(7);
    check("tmo_c8_err", err_timeout, 0);
    tick();
    check("tmo_c9_err", err_timeout, 1);
    check("tmo_c9_stall", stall_cnt, 8);
    ticks(6);
    check("tmo_c15_err", err_timeout, 1);
    ram_wr(8'h10, LA);
    ram_wr(8'h20, LB);
    check("tmo_c17_err", err_timeout, 1);
    check("tmo_c17_out_valid", bus.out_valid, 0);
    #1;
    rst = 1'b1;
    #1;
    check("arst_out_valid", bus.out_valid, 0);
    check("arst_req_ready", bus.req_ready, 1);
    check("arst_err", err_timeout, 0);
    check("arst_stall", stall_cnt, 0);
    check("arst_rd_addr_0", rd_addr_0, 0);
    check("arst_label_a", bus.out_label_a, 0);
    ticks(2);
    rst = 1'b0;
    tick();
    check("post_rst_req_ready", bus.req_ready, 1);
    check("post_rst_out_valid", bus.out_valid, 0);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
